// File: rtl/bcd_number_entry.sv
// Keypad number-entry block: shifts decimal key presses into a BCD working
// register with backspace, clear and overflow handling, and hands the
// committed operand downstream through a valid/ready handshake.
module bcd_number_entry #(
  parameter  int NUM_DIGITS = 4,
  localparam int W          = 4 * NUM_DIGITS,
  localparam int CW         = $clog2(NUM_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [3:0]    key_code,
  output logic [W-1:0]  display_value,
  output logic [CW-1:0] digit_count,
  output logic          entry_full,
  output logic          overflow_err,
  output logic [W-1:0]  number_out,
  output logic          num_valid,
  input  logic          num_ready
);

  localparam logic [3:0] KEY_BACK   = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_COMMIT = 4'hC;

  typedef enum logic [1:0] {IDLE, ENTRY, FULL, HOLD} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  display_q, display_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  number_q, number_d;
  logic          valid_q, valid_d;
  logic          key_valid_q;
  logic          key_event;

  assign key_event = key_valid & ~key_valid_q;

  // Next-state logic: one key event per rising strobe, HOLD waits for the handshake
  always_comb begin
    state_d   = state_q;
    display_d = display_q;
    count_d   = count_q;
    ovf_d     = 1'b0;
    number_d  = number_q;
    valid_d   = valid_q;
    if (state_q == HOLD) begin
      if ((key_event && key_code == KEY_CLEAR) || num_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    end else if (key_event) begin
      if (key_code <= 4'd9) begin
        if (state_q == FULL) begin
          ovf_d = 1'b1;
        end else if (state_q == ENTRY || key_code != 4'd0) begin
          // The working register is all zeros in IDLE, so shifting also covers the first digit
          display_d = (display_q << 4) | W'(key_code);
          count_d   = count_q + CW'(1);
          state_d   = (count_d == CW'(NUM_DIGITS)) ? FULL : ENTRY;
        end
      end else if (key_code == KEY_BACK) begin
        if (count_q != '0) begin
          display_d = display_q >> 4;
          count_d   = count_q - CW'(1);
          state_d   = (count_d == '0) ? IDLE : ENTRY;
        end
      end else if (key_code == KEY_CLEAR) begin
        display_d = '0;
        count_d   = '0;
        state_d   = IDLE;
      end else if (key_code == KEY_COMMIT) begin
        number_d  = display_q;
        valid_d   = 1'b1;
        display_d = '0;
        count_d   = '0;
        state_d   = HOLD;
      end
    end
  end

  // State registers; the strobe delay flop resets high so a key held through reset is not an event
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      display_q   <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      number_q    <= '0;
      valid_q     <= 1'b0;
      key_valid_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      display_q   <= display_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      number_q    <= number_d;
      valid_q     <= valid_d;
      key_valid_q <= key_valid;
    end
  end

  assign display_value = display_q;
  assign digit_count   = count_q;
  assign entry_full    = (state_q == FULL);
  assign overflow_err  = ovf_q;
  assign number_out    = number_q;
  assign num_valid     = valid_q;

endmodule

// File: tb/tb_bcd_number_entry.sv
// Self-checking bench for bcd_number_entry: a 4-digit and a 6-digit instance
// share the same keypad stimulus and are compared every cycle against a
// decimal-arithmetic reference model.
module tb_bcd_number_entry;

   logic clk = 1'b0;
   logic reset;
   logic keyValid;
   logic [3:0] keyCode;
   logic numReady;

   logic [15:0] display4, number4;
   logic [2:0]  count4;
   logic        full4, ovf4, valid4;
   logic [23:0] display6, number6;
   logic [2:0]  count6;
   logic        full6, ovf6, valid6;

   int checkCount = 0;
   int failCount = 0;

   int  mN[2] = '{4, 6};
   int  mVal[2];
   int  mCnt[2];
   int  mNum[2];
   bit  mHold[2];
   bit  mOvf[2];
   bit  mPrevKey;

   bcd_number_entry #(.NUM_DIGITS(4)) dut4 (
      .clk(clk), .reset(reset), .key_valid(keyValid), .key_code(keyCode),
      .display_value(display4), .digit_count(count4), .entry_full(full4),
      .overflow_err(ovf4), .number_out(number4), .num_valid(valid4),
      .num_ready(numReady)
   );

   bcd_number_entry #(.NUM_DIGITS(6)) dut6 (
      .clk(clk), .reset(reset), .key_valid(keyValid), .key_code(keyCode),
      .display_value(display6), .digit_count(count6), .entry_full(full6),
      .overflow_err(ovf6), .number_out(number6), .num_valid(valid6),
      .num_ready(numReady)
   );

   // Free-running clock, inputs change on the falling edge
   always #5 clk = ~clk;

   // Decimal value rendered as packed BCD, least significant digit in the low nibble
   function automatic logic [31:0] toBcd(input int value);
      logic [31:0] result = '0;
      int v = value;
      for (int k = 0; k < 8; k++) begin
         result[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return result;
   endfunction

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference model: the operand is a plain decimal number plus a digit count
   task automatic updateModel(input logic kv, input logic [3:0] code, input logic ready, input logic rst);
      bit ev;
      ev = kv && !mPrevKey;
      mPrevKey = rst ? 1'b1 : kv;
      for (int i = 0; i < 2; i++) begin
         mOvf[i] = 1'b0;
         if (rst) begin
            mVal[i] = 0; mCnt[i] = 0; mNum[i] = 0; mHold[i] = 1'b0;
         end else if (mHold[i]) begin
            if ((ev && code == 4'hB) || ready) mHold[i] = 1'b0;
         end else if (ev) begin
            if (code <= 4'd9) begin
               if (mCnt[i] == mN[i]) mOvf[i] = 1'b1;
               else if (mCnt[i] > 0 || code != 4'd0) begin
                  mVal[i] = mVal[i] * 10 + int'(code);
                  mCnt[i]++;
               end
            end else if (code == 4'hA) begin
               if (mCnt[i] > 0) begin
                  mVal[i] = mVal[i] / 10;
                  mCnt[i]--;
               end
            end else if (code == 4'hB) begin
               mVal[i] = 0; mCnt[i] = 0;
            end else if (code == 4'hC) begin
               mNum[i] = mVal[i]; mHold[i] = 1'b1;
               mVal[i] = 0; mCnt[i] = 0;
            end
         end
      end
   endtask

   // Compare both instances against the model after the most recent edge
   task automatic compareAll();
      checkOutput("display4", 32'(display4), toBcd(mVal[0]));
      checkOutput("count4",   32'(count4),   32'(mCnt[0]));
      checkOutput("full4",    32'(full4),    32'(mCnt[0] == mN[0]));
      checkOutput("ovf4",     32'(ovf4),     32'(mOvf[0]));
      checkOutput("number4",  32'(number4),  toBcd(mNum[0]));
      checkOutput("valid4",   32'(valid4),   32'(mHold[0]));
      checkOutput("display6", 32'(display6), toBcd(mVal[1]));
      checkOutput("count6",   32'(count6),   32'(mCnt[1]));
      checkOutput("full6",    32'(full6),    32'(mCnt[1] == mN[1]));
      checkOutput("ovf6",     32'(ovf6),     32'(mOvf[1]));
      checkOutput("number6",  32'(number6),  toBcd(mNum[1]));
      checkOutput("valid6",   32'(valid6),   32'(mHold[1]));
   endtask

   // One clock cycle: drive inputs, advance the model, check after the edge
   task automatic applyStimulus(input logic kv, input logic [3:0] code, input logic ready, input logic rst);
      keyValid = kv;
      keyCode  = code;
      numReady = ready;
      reset    = rst;
      updateModel(kv, code, ready, rst);
      @(negedge clk);
      compareAll();
   endtask

   task automatic pressKey(input logic [3:0] code);
      applyStimulus(1'b1, code, 1'b0, 1'b0);
      applyStimulus(1'b0, code, 1'b0, 1'b0);
   endtask

   // Directed scenarios first, then a long randomized run
   initial begin
      logic [3:0] rc;
      mPrevKey = 1'b1;
      for (int i = 0; i < 2; i++) begin
         mVal[i] = 0; mCnt[i] = 0; mNum[i] = 0; mHold[i] = 1'b0; mOvf[i] = 1'b0;
      end
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);

      for (int d = 1; d <= 6; d++) pressKey(4'(d));
      pressKey(4'h7);
      pressKey(4'hB);
      pressKey(4'h1); pressKey(4'h2); pressKey(4'hA);
      pressKey(4'hA); pressKey(4'hA);
      pressKey(4'h0); pressKey(4'h0); pressKey(4'h7);
      pressKey(4'hB);
      pressKey(4'hC);
      applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
      pressKey(4'h4); pressKey(4'h2); pressKey(4'hC);
      repeat (3) applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      pressKey(4'h9);
      applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
      repeat (10) applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'h3, 1'b0, 1'b0);
      pressKey(4'hD); pressKey(4'hF);
      pressKey(4'hC); pressKey(4'hB);
      pressKey(4'h1); pressKey(4'h2);
      applyStimulus(1'b1, 4'h5, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'h5, 1'b0, 1'b0);

      for (int n = 0; n < 1500; n++) begin
         case ($urandom_range(0, 9))
            0: rc = 4'hA;
            1: rc = 4'(12 + $urandom_range(0, 3));
            default: rc = 4'($urandom_range(0, 9));
         endcase
         if ($urandom_range(0, 29) == 0) rc = 4'hB;
         applyStimulus(1'($urandom_range(0, 1)), rc, 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 99) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
